// File: rtl/alu_pkg.sv
// Shared widths for the datapath logic unit.
// Holds the operand width used by the OR block beside the other logic-unit widths.
package alu_pkg;

  localparam int OR_W = 5;

  typedef logic [OR_W-1:0] or_word_t;

endpackage

// File: rtl/or_1bit.sv
// Single-bit OR cell; the OR block is built by replicating this cell per bit.
module or_1bit (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a | b;

endmodule

// File: rtl/or_5bit.sv
// Bitwise OR of two operands with a registered result, an any-bit-set flag and a
// sticky OR-accumulator for downstream pipeline stages.
module or_5bit
  import alu_pkg::*;
#(
  parameter int WIDTH = OR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             in_vld,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] out_q,
  output logic             out_vld,
  output logic             any_set,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] res_q, res_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // One cell per bit keeps an X on one operand bit confined to its result bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    or_1bit u_or (
      .a (inp_a[i]),
      .b (inp_b[i]),
      .y (out[i])
    );
  end

  assign any_set = |out;

  always_comb begin
    res_d = res_q;
    vld_d = 1'b0;
    if (in_vld) begin
      res_d = out;
      vld_d = 1'b1;
    end
  end

  // Clear takes priority over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q | out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
      acc_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      acc_q <= acc_d;
    end
  end

  assign out_q   = res_q;
  assign out_vld = vld_q;
  assign acc     = acc_q;

endmodule

// File: tb/tb_or_5bit.sv
// Self-checking bench for or_5bit: directed cases plus randomized traffic against a
// cycle-level reference model.
module tb_or_5bit;

  logic       clk;
  logic       rst_n;
  logic [4:0] out;
  logic [4:0] inp_a;
  logic [4:0] inp_b;
  logic       in_vld;
  logic       acc_en;
  logic       acc_clr;
  logic [4:0] out_q;
  logic       out_vld;
  logic       any_set;
  logic [4:0] acc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [4:0] m_q;
  logic       m_vld;
  logic [4:0] m_acc;

  or_5bit #(.WIDTH(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .out     (out),
    .inp_a   (inp_a),
    .inp_b   (inp_b),
    .in_vld  (in_vld),
    .acc_en  (acc_en),
    .acc_clr (acc_clr),
    .out_q   (out_q),
    .out_vld (out_vld),
    .any_set (any_set),
    .acc     (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, update the model from the inputs seen there, settle 1 unit.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_q = '0; m_vld = 1'b0; m_acc = '0;
    end else begin
      if (in_vld) begin
        m_q   = inp_a | inp_b;
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (acc_clr)     m_acc = '0;
      else if (acc_en) m_acc = m_acc | (inp_a | inp_b);
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (out_q !== 5'b00000) begin n_fail++; $display("FAIL reset_out_q got=%b want=%b", out_q, 5'b00000); end
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got=%b want=0", out_vld); end
    n_checks++;
    if (acc !== 5'b00000) begin n_fail++; $display("FAIL reset_acc got=%b want=%b", acc, 5'b00000); end
  endtask

  task automatic test_comb();
    logic [4:0] va [7];
    logic [4:0] vb [7];
    logic [4:0] vy [7];
    va[0] = 5'b00010; vb[0] = 5'b11100; vy[0] = 5'b11110;
    va[1] = 5'b10001; vb[1] = 5'b01101; vy[1] = 5'b11101;
    va[2] = 5'b01000; vb[2] = 5'b11100; vy[2] = 5'b11100;
    va[3] = 5'b00100; vb[3] = 5'b11100; vy[3] = 5'b11100;
    va[4] = 5'b10101; vb[4] = 5'b01101; vy[4] = 5'b11101;
    va[5] = 5'b00000; vb[5] = 5'b00000; vy[5] = 5'b00000;
    va[6] = 5'b11111; vb[6] = 5'b00000; vy[6] = 5'b11111;
    for (int i = 0; i < 7; i++) begin
      inp_a = va[i];
      inp_b = vb[i];
      #20;
      n_checks++;
      if (out !== vy[i]) begin
        n_fail++;
        $display("FAIL comb_out[%0d] %b|%b got=%b want=%b", i, va[i], vb[i], out, vy[i]);
      end
      n_checks++;
      if (any_set !== (vy[i] != 5'b00000)) begin
        n_fail++;
        $display("FAIL comb_any_set[%0d] got=%b want=%b", i, any_set, (vy[i] != 5'b00000));
      end
    end
  endtask

  task automatic test_register();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    inp_a = 5'b00010; inp_b = 5'b11100; in_vld = 1'b1;
    tick();
    n_checks++;
    if (out_q !== 5'b11110) begin n_fail++; $display("FAIL reg_capture out_q got=%b want=11110", out_q); end
    n_checks++;
    if (out_vld !== 1'b1) begin n_fail++; $display("FAIL reg_capture out_vld got=%b want=1", out_vld); end
    in_vld = 1'b0; inp_a = 5'b00001; inp_b = 5'b00000;
    tick();
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reg_pulse out_vld got=%b want=0", out_vld); end
    n_checks++;
    if (out_q !== 5'b11110) begin n_fail++; $display("FAIL reg_hold out_q got=%b want=11110", out_q); end
  endtask

  task automatic test_accum();
    acc_en = 1'b1;
    inp_a = 5'b00001; inp_b = 5'b00000; tick();
    inp_a = 5'b00100; tick();
    inp_a = 5'b10000; tick();
    n_checks++;
    if (acc !== 5'b10101) begin n_fail++; $display("FAIL acc_accumulate got=%b want=10101", acc); end
    acc_en = 1'b0; inp_a = 5'b01010; tick();
    n_checks++;
    if (acc !== 5'b10101) begin n_fail++; $display("FAIL acc_hold got=%b want=10101", acc); end
    acc_en = 1'b1; acc_clr = 1'b1; tick();
    n_checks++;
    if (acc !== 5'b00000) begin n_fail++; $display("FAIL acc_clr_priority got=%b want=00000", acc); end
    acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    acc_en = 1'b1; inp_a = 5'b10101; inp_b = 5'b00000; tick();
    acc_en = 1'b0; in_vld = 1'b1; inp_b = 5'b01101; tick();
    in_vld = 1'b0;
    n_checks++;
    if (out_q !== 5'b11101 || acc !== 5'b10101) begin
      n_fail++; $display("FAIL async_setup out_q=%b acc=%b want 11101/10101", out_q, acc);
    end
    #1;
    rst_n = 1'b0;
    #1;
    m_q = '0; m_vld = 1'b0; m_acc = '0;
    n_checks++;
    if (out_q !== 5'b00000) begin n_fail++; $display("FAIL async_out_q got=%b want=00000", out_q); end
    n_checks++;
    if (acc !== 5'b00000) begin n_fail++; $display("FAIL async_acc got=%b want=00000", acc); end
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL async_out_vld got=%b want=0", out_vld); end
    inp_a = 5'b01001; inp_b = 5'b00010;
    #1;
    n_checks++;
    if (out !== 5'b01011) begin n_fail++; $display("FAIL async_out_tracks got=%b want=01011", out); end
    tick();
    n_checks++;
    if (out_q !== 5'b00000 || acc !== 5'b00000) begin
      n_fail++; $display("FAIL async_hold out_q=%b acc=%b want 0/0", out_q, acc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] exp_out;
    for (int i = 0; i < 300; i++) begin
      inp_a   = 5'($urandom);
      inp_b   = 5'($urandom);
      in_vld  = 1'($urandom);
      acc_en  = 1'($urandom);
      acc_clr = ($urandom_range(0, 7) == 0);
      exp_out = inp_a | inp_b;
      #1;
      n_checks++;
      if (out !== exp_out || any_set !== (exp_out != 0)) begin
        n_fail++;
        $display("FAIL rand_comb[%0d] out=%b any=%b want %b/%b", i, out, any_set, exp_out, (exp_out != 0));
      end
      tick();
      n_checks++;
      if (out_q !== m_q || out_vld !== m_vld || acc !== m_acc) begin
        n_fail++;
        $display("FAIL rand_regs[%0d] out_q=%b vld=%b acc=%b want %b/%b/%b",
                 i, out_q, out_vld, acc, m_q, m_vld, m_acc);
      end
    end
    in_vld = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inp_a = '0; inp_b = '0;
    in_vld = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    m_q = '0; m_vld = 1'b0; m_acc = '0;
    test_reset();
    test_comb();
    test_register();
    test_accum();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
